rx_frame_ctrl: RTL



---
 rtl/rx_frame_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: per-frame receive controller. Waits for the end of a received
// frame, decides whether to keep it from the MAC/transport verdicts, then
// drains the data store through a one-word hold register so the final word
// can be tagged with m_last when the store stream ends.
module rx_frame_ctrl #(
  parameter int DATA_SIZE = 16,
  parameter int MAX_WORDS = 750,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 rx_done,
  input  logic                 rx_kill,
  input  logic                 transport_valid,
  input  logic                 udp_kill,
  input  logic                 ethertype_ok,
  input  logic                 store_axiov,
  input  logic [DATA_SIZE-1:0] store_axiod,
  output logic                 read_request,
  output logic                 m_valid,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic [15:0]          accepted_count,
  output logic [15:0]          dropped_count
);

  localparam int WCNT_W = $clog2(MAX_WORDS + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WORDS);
  localparam logic [TCNT_W-1:0] TCNT_LIM = TCNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECV   = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic                 rxd_prev_q;
  logic                 axiov_prev_q;
  logic [DATA_SIZE-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic                 rdreq_q;
  logic                 mvalid_q, mvalid_d;
  logic                 mlast_q, mlast_d;
  logic [DATA_SIZE-1:0] mdata_q, mdata_d;
  logic [15:0]          acc_q, acc_d;
  logic [15:0]          drop_q, drop_d;
  logic                 acc_inc, drop_inc;
  logic                 accept;
  logic                 capture;

  // Frame verdict: transport layer result dominates; otherwise a plain
  // ethertype match is enough as long as the MAC check passed.
  always_comb begin
    accept = 1'b0;
    if (transport_valid) accept = ~udp_kill & ~rx_kill;
    else if (ethertype_ok) accept = ~rx_kill;
  end

  // Next-state, hold register, output word and counter-increment logic.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    mvalid_d    = 1'b0;
    mlast_d     = 1'b0;
    mdata_d     = mdata_q;
    acc_inc     = 1'b0;
    drop_inc    = 1'b0;
    capture     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_RECV;
      end

      S_RECV: begin
        if (rx_done && !rxd_prev_q) state_d = S_DECIDE;
      end

      S_DECIDE: begin
        hold_full_d = 1'b0;
        wcnt_d      = '0;
        tcnt_d      = '0;
        if (accept) begin
          state_d = S_DRAIN;
        end else begin
          state_d  = S_IDLE;
          drop_inc = 1'b1;
        end
      end

      default: begin // S_DRAIN
        // Words past the per-frame limit are silently dropped.
        capture = store_axiov && (wcnt_q < WCNT_MAX);
        if (capture) begin
          hold_d      = store_axiod;
          hold_full_d = 1'b1;
          wcnt_d      = wcnt_q + WCNT_W'(1);
          // A new word pushes the previous one out, which is not the last.
          if (hold_full_q) begin
            mvalid_d = 1'b1;
            mdata_d  = hold_q;
          end
        end

        if (axiov_prev_q && !store_axiov) begin
          // End of stream: the held word is the final one of the frame.
          // axiov_prev_q implies at least one word was captured.
          mvalid_d = 1'b1;
          mlast_d  = 1'b1;
          mdata_d  = hold_q;
          state_d  = S_IDLE;
          acc_inc  = 1'b1;
        end else if (!hold_full_q && !store_axiov) begin
          // Timeout only runs while the store has produced nothing yet.
          if (tcnt_q == TCNT_LIM) begin
            state_d  = S_IDLE;
            drop_inc = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end
    endcase

    acc_d  = (acc_inc  && acc_q  != 16'hFFFF) ? acc_q  + 16'd1 : acc_q;
    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  // State, datapath and statistics registers; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rxd_prev_q   <= 1'b0;
      axiov_prev_q <= 1'b0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      wcnt_q       <= '0;
      tcnt_q       <= '0;
      rdreq_q      <= 1'b0;
      mvalid_q     <= 1'b0;
      mlast_q      <= 1'b0;
      mdata_q      <= '0;
      acc_q        <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      rxd_prev_q   <= rx_done;
      axiov_prev_q <= (state_q == S_DRAIN) && store_axiov;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      wcnt_q       <= wcnt_d;
      tcnt_q       <= tcnt_d;
      rdreq_q      <= (state_d == S_DRAIN);
      mvalid_q     <= mvalid_d;
      mlast_q      <= mlast_d;
      mdata_q      <= mdata_d;
      acc_q        <= acc_d;
      drop_q       <= drop_d;
    end
  end

  assign read_request   = rdreq_q;
  assign m_valid        = mvalid_q;
  assign m_last         = mlast_q;
  assign m_data         = mdata_q;
  assign busy           = (state_q != S_IDLE);
  assign accepted_count = acc_q;
  assign dropped_count  = drop_q;

endmodule
